// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller.
// Latches a 128-bit cipher key, expands it into 11 round keys at one round
// key per cycle (one shared 4-byte SubWord), stores them, and serves indexed
// reads with a one-cycle latency.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   key_load   request to latch key_in and start expansion
//   key_in     cipher key, word w0 in [127:96]
//   key_ready  high while a key_load would be accepted (IDLE / READY)
//   busy       expansion in progress
//   key_valid  all 11 round keys stored and readable
//   rd_en      round-key read request
//   rd_idx     round-key index 0..10
//   rd_valid   rd_key / rd_err valid (single-cycle pulse, one cycle after rd_en)
//   rd_key     requested round key (holds when rd_valid is low)
//   rd_err     read rejected (index > 10 or key_valid low)
//   zeroize    (only with AES_KSCHED_ZEROIZE_EN) clears all round keys, forces IDLE
//
// Optional feature macro: AES_KSCHED_ZEROIZE_EN
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KSCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         key_valid,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic         rd_valid,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, 0 maps to 0) followed
  // by the FIPS-197 affine transform; avoids a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv, b;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    b    = inv;
    sbox = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  state_t       state_r, state_nx;
  logic [127:0] slots_r [0:10];
  logic [127:0] work_key_r;
  logic [7:0]   rcon_r;
  logic [3:0]   round_r;
  logic         busy_r, key_valid_r, key_ready_r;
  logic         rd_valid_r, rd_err_r;
  logic [127:0] rd_key_r;
  logic         accept_s, zeroize_s, expand_s;
  logic         busy_nx, key_valid_nx, key_ready_nx;
  logic [31:0]  rot_s, sub_s, w0_s, w1_s, w2_s, w3_s;
  logic [127:0] next_key_s;

`ifdef AES_KSCHED_ZEROIZE_EN
  assign zeroize_s = zeroize;
`else
  assign zeroize_s = 1'b0;
`endif

  // One round of key expansion from the previously written round key.
  always_comb begin
    rot_s      = {work_key_r[23:0], work_key_r[31:24]};
    sub_s      = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    w0_s       = work_key_r[127:96] ^ sub_s ^ {rcon_r, 24'h000000};
    w1_s       = work_key_r[95:64] ^ w0_s;
    w2_s       = work_key_r[63:32] ^ w1_s;
    w3_s       = work_key_r[31:0] ^ w2_s;
    next_key_s = {w0_s, w1_s, w2_s, w3_s};
  end

  // FSM next-state and next-output logic.
  always_comb begin
    state_nx = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE, READY: begin
        if (key_load) begin
          state_nx = EXPAND;
          accept_s = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      EXPAND: begin
        if (round_r == 4'd10) state_nx = READY;
        else                  state_nx = EXPAND;
      end
      default: state_nx = IDLE;
    endcase
    // Zeroize outranks any load and aborts an expansion in flight.
    if (zeroize_s) begin
      state_nx = IDLE;
      accept_s = 1'b0;
    end else begin
      state_nx = state_nx;
    end
    expand_s     = (state_r == EXPAND) && !zeroize_s;
    busy_nx      = (state_nx == EXPAND);
    key_valid_nx = (state_nx == READY);
    key_ready_nx = (state_nx != EXPAND);
  end

  // FSM state and status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      key_valid_r <= 1'b0;
      key_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nx;
      busy_r      <= busy_nx;
      key_valid_r <= key_valid_nx;
      key_ready_r <= key_ready_nx;
    end
  end

  // Round-key storage, round counter and rcon progression.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) slots_r[i] <= 128'h0;
      work_key_r <= 128'h0;
      rcon_r     <= 8'h01;
      round_r    <= 4'd0;
    end else if (zeroize_s) begin
      for (int i = 0; i < 11; i++) slots_r[i] <= 128'h0;
      work_key_r <= 128'h0;
      rcon_r     <= 8'h01;
      round_r    <= 4'd0;
    end else if (accept_s) begin
      slots_r[0] <= key_in;
      work_key_r <= key_in;
      rcon_r     <= 8'h01;
      round_r    <= 4'd1;
    end else if (expand_s) begin
      slots_r[round_r] <= next_key_s;
      work_key_r       <= next_key_s;
      // Counter and rcon stop at round 10 (rcon stays 8'h36).
      if (round_r != 4'd10) begin
        round_r <= round_r + 4'd1;
        rcon_r  <= xtime(rcon_r);
      end
    end
  end

  // Read port; slots are sampled before this edge's writes, so a read that
  // coincides with a new load returns the old key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      rd_key_r   <= 128'h0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en && key_valid_r && (rd_idx <= 4'd10)) begin
        rd_key_r <= slots_r[rd_idx];
        rd_err_r <= 1'b0;
      end else if (rd_en) begin
        rd_key_r <= 128'h0;
        rd_err_r <= 1'b1;
      end else begin
        rd_err_r <= 1'b0;
      end
    end
  end

  assign key_ready = key_ready_r;
  assign busy      = busy_r;
  assign key_valid = key_valid_r;
  assign rd_valid  = rd_valid_r;
  assign rd_err    = rd_err_r;
  assign rd_key    = rd_key_r;

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds, fixed.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_load  input  1  request to latch key_in and start expansion.
REQ-005 key_in  input  128  cipher key, word w0 in [127:96].
REQ-006 key_ready  output  1  high when a key_load is accepted this cycle.
REQ-007 busy  output  1  expansion in progress.
REQ-008 key_valid  output  1  all 11 round keys stored and readable.
REQ-009 rd_en  input  1  round-key read request.
REQ-010 rd_idx  input  4  round-key index, 0..10.
REQ-011 rd_valid  output  1  rd_key/rd_err valid, one cycle after rd_en.
REQ-012 rd_key  output  128  requested round key.
REQ-013 rd_err  output  1  read rejected (index > 10 or key_valid low).

Function
REQ-014 FSM states IDLE, EXPAND, READY; IDLE->EXPAND on accepted load; EXPAND->READY after round 10 written; READY->EXPAND on accepted load.
REQ-015 key_ready = 1 in IDLE and READY, 0 in EXPAND; key_load in EXPAND is ignored, not queued.
REQ-016 Accept cycle (T0): key_in written to slot 0, rcon register set to 8'h01, busy rises at T1, key_valid falls at T1.
REQ-017 Exactly one round key per cycle: slot r (1..10) written at end of cycle T0+r, using one shared 4-byte SubWord on RotWord of the previous round's w3.
REQ-018 Round-key math per FIPS-197: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
REQ-019 rcon advances by GF(2^8) xtime each round (01,02,04,...,80,1b,36); no lookup table.
REQ-020 Round counter 4 bits, counts 1..10, no wrap beyond 10.
REQ-021 busy falls and key_valid rises at T11; total load-to-valid latency 11 cycles.
REQ-022 Reads: rd_en at cycle N -> rd_valid=1 at N+1 with rd_key = slot[rd_idx], rd_err=0, when key_valid=1 and rd_idx<=10.
REQ-023 rd_idx 11..15, or key_valid=0 at N -> rd_valid=1, rd_key=0, rd_err=1 at N+1.
REQ-024 rd_valid, rd_err single-cycle pulses; rd_key holds last value when rd_valid=0.
REQ-025 Read and key_load in same cycle in READY: read returns old-key value; new expansion starts.

Reset
REQ-026 rst_n low: state IDLE; busy, key_valid, rd_valid, rd_err = 0; rd_key = 0; rcon = 8'h01; counter = 0; key slots = 0.
REQ-027 Reset mid-EXPAND aborts immediately; no partial key becomes valid; key_ready = 1 in the first cycle after release.

Configuration
REQ-028 Macro AES_KSCHED_ZEROIZE_EN: when defined, adds input zeroize (1 bit). A zeroize pulse clears all 11 slots to 0, key_valid to 0, and forces IDLE in one cycle. zeroize has priority over key_load and aborts EXPAND. Reads on the following cycle return rd_err=1.
REQ-029 Without AES_KSCHED_ZEROIZE_EN: no zeroize port; contents clear only by reset or overwrite.

Verification
REQ-030 Load 2b7e151628aed2a6abf7158809cf4f3c -> key_valid at T11; read idx1 = a0fafe1788542cb123a339392a6c7605; read idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 Second key_load at T5 -> ignored (key_ready=0); keys match the first key only; key_valid still at T11.
REQ-032 rd_idx=12 in READY -> rd_valid=1, rd_err=1, rd_key=0 next cycle; read idx0 before any load -> rd_err=1.
REQ-033 rst_n low at T6, released -> busy=0, key_valid=0, key_ready=1; reload completes normally 11 cycles later.
REQ-034 Load all-zero key -> idx10 = b4ef5bcb3e92e21123e951cf6f8f188e; rcon reaches 36 in round 10.
REQ-035 (AES_KSCHED_ZEROIZE_EN) zeroize in READY -> key_valid=0 next cycle; read idx0 -> rd_err=1, rd_key=0.
